// File: rtl/sram_sp_arbiter.sv
// sram_sp_arbiter: round-robin sharing of one single-port synchronous SRAM.
// Define SRAM_ARB_LOCK_EN to add per-requester lock for atomic RMW sequences.
module sram_sp_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int WORD_AW = AW - ((DW / 8) >> 1),
  parameter int NREQ    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*WORD_AW-1:0]    req_waddr,
  input  logic [NREQ*DW-1:0]         req_din,
  input  logic [NREQ*(DW/8)-1:0]     req_sel,
`ifdef SRAM_ARB_LOCK_EN
  input  logic [NREQ-1:0]            req_lock,
`endif
  output logic [NREQ-1:0]            req_gnt,
  output logic [NREQ-1:0]            req_ack,
  output logic [DW-1:0]              req_dout,
  output logic                       sram_ce,
  output logic                       sram_we,
  output logic                       sram_oe,
  output logic [WORD_AW-1:0]         sram_waddr,
  output logic [DW-1:0]              sram_din,
  output logic [(DW/8)-1:0]          sram_sel,
  input  logic [DW-1:0]              sram_dout
);

  localparam int SW = DW / 8;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_rr;
  logic [PW-1:0]   w_rr_nxt;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_win;
  logic            w_any;
  logic            w_go;
  int              w_k;

`ifdef SRAM_ARB_LOCK_EN
  logic            r_locked;
  logic            w_locked_nxt;
  logic [PW-1:0]   r_lk;
  logic [PW-1:0]   w_lk_nxt;
`endif

  function automatic logic [PW-1:0] f_next(
    input logic [PW-1:0] k
  );
    if (int'(k) == NREQ - 1) begin
      return '0;
    end
    return k + 1'b1;
  endfunction

  // A held lock masks every other requester out of the search.
  always_comb begin
    w_elig = req_valid;
`ifdef SRAM_ARB_LOCK_EN
    if (r_locked) begin
      w_elig       = '0;
      w_elig[r_lk] = req_valid[r_lk];
    end
`endif
  end

  always_comb begin
    int j;
    w_any = 1'b0;
    w_win = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(r_rr) + i) % NREQ;
      if (!w_any && w_elig[j]) begin
        w_any = 1'b1;
        w_win = PW'(j);
      end
    end
  end

  assign w_go = w_any & rst;
  assign w_k  = int'(w_win);

  always_comb begin
    w_gnt = '0;
    if (w_go) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  assign req_gnt = w_gnt;

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    sram_waddr = '0;
    sram_din   = '0;
    sram_sel   = '0;
    if (w_go) begin
      sram_ce    = 1'b1;
      sram_we    = req_we[w_win];
      sram_oe    = ~req_we[w_win];
      sram_waddr = req_waddr[w_k*WORD_AW +: WORD_AW];
      sram_din   = req_din[w_k*DW +: DW];
      sram_sel   = req_sel[w_k*SW +: SW];
    end
  end

`ifdef SRAM_ARB_LOCK_EN
  // Pointer is frozen while locked and resumes after the lock owner.
  always_comb begin
    w_rr_nxt     = r_rr;
    w_locked_nxt = r_locked;
    w_lk_nxt     = r_lk;
    if (r_locked) begin
      if ((w_go && !req_lock[r_lk]) ||
          (!req_valid[r_lk] && !req_lock[r_lk])) begin
        w_locked_nxt = 1'b0;
        w_rr_nxt     = f_next(r_lk);
      end
    end else if (w_go) begin
      w_rr_nxt = f_next(w_win);
      if (req_lock[w_win]) begin
        w_locked_nxt = 1'b1;
        w_lk_nxt     = w_win;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_locked <= 1'b0;
      r_lk     <= '0;
    end else begin
      r_locked <= w_locked_nxt;
      r_lk     <= w_lk_nxt;
    end
  end
`else
  always_comb begin
    w_rr_nxt = r_rr;
    if (w_go) begin
      w_rr_nxt = f_next(w_win);
    end
  end
`endif

  always_comb begin
    w_state_nxt = S_IDLE;
    if (|w_gnt) begin
      w_state_nxt = S_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_ack   <= w_gnt;
    end
  end

  assign req_ack  = (r_state == S_BUSY) ? r_ack : '0;
  assign req_dout = sram_dout;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// tb_sram_sp_arbiter: scoreboard bench with a reference arbiter and memory.
// Stimulus issue pushes expected acks; a monitor pops them on req_ack.
module tb_sram_sp_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int WORD_AW = AW - (SW >> 1);
  localparam int NREQ    = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_we;
  logic [NREQ*WORD_AW-1:0] req_waddr;
  logic [NREQ*DW-1:0]      req_din;
  logic [NREQ*SW-1:0]      req_sel;
  logic [NREQ-1:0]         req_gnt;
  logic [NREQ-1:0]         req_ack;
  logic [DW-1:0]           req_dout;
  logic                    sram_ce;
  logic                    sram_we;
  logic                    sram_oe;
  logic [WORD_AW-1:0]      sram_waddr;
  logic [DW-1:0]           sram_din;
  logic [SW-1:0]           sram_sel;
  logic [DW-1:0]           sram_dout;
`ifdef SRAM_ARB_LOCK_EN
  logic [NREQ-1:0]         req_lock;
  initial req_lock = '0;
`endif

  sram_sp_arbiter #(
    .AW(AW), .DW(DW), .WORD_AW(WORD_AW), .NREQ(NREQ)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_waddr(req_waddr), .req_din(req_din),
    .req_sel(req_sel),
`ifdef SRAM_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_gnt(req_gnt), .req_ack(req_ack),
    .req_dout(req_dout),
    .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_oe(sram_oe), .sram_waddr(sram_waddr),
    .sram_din(sram_din), .sram_sel(sram_sel),
    .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Environment SRAM: registered read, byte-select write, preload port.
  logic [DW-1:0] smem [64];
  logic          pl_we = 1'b0;
  logic [5:0]    pl_a;
  logic [DW-1:0] pl_d;
  always @(posedge clk) begin
    if (pl_we) begin
      smem[pl_a] <= pl_d;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < SW; b++)
          if (sram_sel[b])
            smem[sram_waddr[5:0]][b*8 +: 8] <= sram_din[b*8 +: 8];
      end else begin
        sram_dout <= smem[sram_waddr[5:0]];
      end
    end
  end

  typedef struct {
    int          idx;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] rmem [64];
  int            m_ptr;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  bit                 p_valid [NREQ];
  bit                 p_we    [NREQ];
  logic [WORD_AW-1:0] p_addr  [NREQ];
  logic [DW-1:0]      p_din   [NREQ];
  logic [SW-1:0]      p_sel   [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = p_valid[i];
      req_we[i]    = p_we[i];
      req_waddr[i*WORD_AW +: WORD_AW] = p_addr[i];
      req_din[i*DW +: DW] = p_din[i];
      req_sel[i*SW +: SW] = p_sel[i];
    end
  endtask

  task automatic set_req(int i, bit we, int a, logic [31:0] d,
                         logic [3:0] s);
    p_valid[i] = 1'b1;
    p_we[i]    = we;
    p_addr[i]  = WORD_AW'(a);
    p_din[i]   = d;
    p_sel[i]   = s;
  endtask

  // One cycle: drive at negedge, predict winner, check, update model.
  task automatic step(int want = -1);
    int k;
    int a;
    k = -1;
    drive();
    #1;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (m_ptr + i) % NREQ;
      if (k < 0 && p_valid[j]) k = j;
    end
    if (want >= 0) chk("order", req_gnt, 64'(1) << want);
    chk("gnt", req_gnt, (k < 0) ? 64'(0) : (64'(1) << k));
    chk("ce", sram_ce, (k >= 0));
    if (k >= 0) begin
      a = int'(p_addr[k][5:0]);
      chk("we", sram_we, p_we[k]);
      chk("oe", sram_oe, !p_we[k]);
      chk("addr", sram_waddr, p_addr[k]);
      chk("sel", sram_sel, p_sel[k]);
      if (p_we[k]) begin
        chk("din", sram_din, p_din[k]);
        for (int b = 0; b < SW; b++)
          if (p_sel[k][b]) rmem[a][b*8 +: 8] = p_din[k][b*8 +: 8];
      end
      q.push_back('{k, !p_we[k], rmem[a], cyc});
      m_ptr = (k + 1) % NREQ;
      p_valid[k] = 1'b0;
    end else begin
      chk("idle_we_oe", {sram_we, sram_oe}, 0);
      chk("idle_sel", sram_sel, 0);
      chk("idle_addr", sram_waddr, 0);
    end
    @(negedge clk);
  endtask

  // Monitor: every nonzero ack must match the oldest outstanding grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (req_ack != '0) begin
          if (q.size() == 0) begin
            chk("ack_unexpected", req_ack, 0);
          end else begin
            e = q.pop_front();
            chk("ack_onehot", req_ack, 64'(1) << e.idx);
            chk("ack_lat", cyc, e.cyc + 1);
            if (e.rd) chk("rdata", req_dout, e.data);
          end
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          chk("ack_missing", req_ack, 64'(1) << e.idx);
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 4'h0);
    drive();
    for (int a = 0; a < 64; a++) begin
      v = $urandom;
      if (a == 'h10) v = 32'hDEADBEEF;
      if (a == 'h20) v = 32'hAABBCCDD;
      rmem[a] = v;
      pl_a = 6'(a);
      pl_d = v;
      pl_we = 1'b1;
      @(negedge clk);
    end
    pl_we = 1'b0;
    chk("rst_gnt", req_gnt, 0);
    chk("rst_ce", sram_ce, 0);
    chk("rst_ack", req_ack, 0);
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    drive();
    rst = 1'b1;
    m_ptr = 0;
    @(negedge clk);

    set_req(0, 0, 'h10, 0, 4'hF);
    step(0);
    chk("t1_rdata", req_dout, 32'hDEADBEEF);

    set_req(1, 1, 'h20, 32'h11223344, 4'b0010);
    step(1);
    set_req(1, 0, 'h20, 0, 4'hF);
    step(1);
    chk("t2_rdata", req_dout, 32'hAABB33DD);

    set_req(0, 1, 3, 5, 4'hF);
    step(0);
    set_req(0, 0, 3, 0, 4'hF);
    step(0);
    chk("t4_rdata", req_dout, 32'h00000005);

    set_req(0, 0, 'h10, 0, 4'hF);
    drive();
    #1;
    chk("t5_gnt", req_gnt, 1);
    p_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_ack_pre", req_ack, 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_ack_rst", req_ack, 0);
    for (int i = 0; i < NREQ; i++) set_req(i, 0, i, 0, 4'hF);
    drive();
    #1;
    chk("t5_gnt_rst", req_gnt, 0);
    chk("t5_ce_rst", sram_ce, 0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    drive();
    #1 rst = 1'b1;
    m_ptr = 0;
    @(negedge clk);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_valid[i]) set_req(i, 0, 'h30 + i, 0, 4'hF);
      step(n % NREQ);
    end

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_valid[i] && ($urandom_range(99) < 55))
          set_req(i, $urandom_range(1), $urandom_range(15),
                  $urandom, 4'($urandom_range(15)));
      step();
    end

    for (int n = 0; n < 8; n++) step();
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    step();
    step();
    chk("q_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_sp_arbiter.md
Name: sram_sp_arbiter

Overview:
- Shares one single-port synchronous SRAM macro (1-cycle read latency, byte-select writes) between NREQ requesters, e.g. instruction fetch, data port and debug/loader.
- Issues at most one SRAM access per cycle using round-robin arbitration.
- Returns a one-cycle-delayed acknowledge, plus read data, to the granted requester.
- Sits between the tile bus adapters and the SRAM wrapper.

Parameters:
- AW, 32: byte address width.
- DW, 32: data width; legal values 8, 16, 32.
- SW, derived, not overridable: bytes per word; 4 for DW=32, 2 for DW=16, 1 for DW=8.
- WORD_AW, AW-(SW>>1): word address width.
- NREQ, 2: number of requesters; legal range 2..8.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester access request.
- req_we  in  NREQ  1=write, 0=read.
- req_waddr  in  NREQ*WORD_AW  word addresses; requester i occupies slice [i*WORD_AW +: WORD_AW].
- req_din  in  NREQ*DW  write data, sliced per requester.
- req_sel  in  NREQ*SW  byte selects, sliced per requester.
- req_gnt  out  NREQ  one-hot; access accepted this cycle.
- req_ack  out  NREQ  one-hot; access completed, one cycle after its gnt.
- req_dout  out  DW  read data; valid with req_ack when the access was a read.
- sram_ce  out  1  chip enable to SRAM.
- sram_we  out  1  write enable to SRAM.
- sram_oe  out  1  output enable to SRAM.
- sram_waddr  out  WORD_AW  SRAM word address.
- sram_din  out  DW  SRAM write data.
- sram_sel  out  SW  SRAM byte selects.
- sram_dout  in  DW  SRAM read data; registered inside the SRAM.

Behaviour:
- Grant path is combinational: requests are evaluated in the same cycle. The SRAM command path is a direct mux of the granted requester's signals onto sram_*.
- Round-robin pointer rr_ptr (clog2(NREQ) bits), reset value 0.
  - Search starts at rr_ptr and wraps modulo NREQ.
  - The first asserted req_valid wins.
- On a grant to index k: rr_ptr <= (k+1) mod NREQ. With no request, rr_ptr holds.
- Winner k:
  - req_gnt[k]=1.
  - sram_ce=1, sram_oe=~req_we[k], sram_we=req_we[k].
  - sram_waddr, sram_din and sram_sel are taken from slice k.
  - sel is forwarded unmodified on reads.
- No winner: sram_ce=0, sram_we=0, sram_oe=0, sram_sel=0. sram_waddr and sram_din are driven 0.
- Requester protocol:
  - Hold req_valid and its payload stable until gnt.
  - A requester may issue back-to-back; a new request may be presented in the same cycle as its ack.
- Completion pipeline: registered ack_q <= req_gnt. req_ack=ack_q. req_dout=sram_dout (combinational from the SRAM's registered output).
  - Throughput: 1 access/cycle.
  - Latency: gnt -> ack = 1 cycle.
  - Write ack carries no meaningful data.
- Two-state FSM, mirrored by ack_q:
  - IDLE: no access in flight.
  - BUSY: access in flight.
  - Transitions:
    - IDLE -> BUSY on any gnt.
    - BUSY -> BUSY on gnt.
    - BUSY -> IDLE on no gnt.
  - There is no wait state; SRAM latency is fixed.
- Reset:
  - rst=0 asynchronously clears rr_ptr, ack_q and the lock state. All req_ack go 0 immediately.
  - An in-flight access is dropped without ack. A write already issued to the SRAM may have landed.
  - While rst=0, req_gnt=0 and sram_ce=0 regardless of req_valid.
- Simultaneous events:
  - All requesters asserted: grants rotate 0,1,..,NREQ-1,0.
  - A single requester asserted: it is granted every cycle.
- Read-after-write to the same address in consecutive cycles returns the new data, because the SRAM write completes before the following read edge.

Optional Feature:
- Macro: SRAM_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NREQ].
  - If the granted requester k has req_lock[k]=1, the arbiter enters LOCKED(k). In LOCKED(k), only requester k can be granted; other requests wait.
  - LOCKED(k) exits on the first granted access from k with req_lock[k]=0, or on a cycle where req_valid[k]=0 and req_lock[k]=0.
  - rr_ptr does not advance during LOCKED. On exit, rr_ptr <= (k+1) mod NREQ.
  - This supports atomic read-modify-write.
- Undefined: the port is absent and behaviour is as above.

Test Plan:
1. Single read: preload mem[0x10]=0xDEADBEEF. Req0 reads 0x10 at cycle t -> gnt[0] at t; ack[0] at t+1 with req_dout=0xDEADBEEF; sram_oe=1 and sram_we=0 at t.
2. Byte write: req1 writes din=0x11223344, sel=4'b0010 to addr 0x20, which holds 0xAABBCCDD. Read back -> 0xAABB33DD.
3. Contention: req0 and req1 request continuously for 6 cycles after reset -> grant order 0,1,0,1,0,1. Each ack follows its gnt by exactly 1 cycle; no cycle has two gnts.
4. Back-to-back: req0 writes 0x5 to addr 3, then reads addr 3 on the next cycle with no competitor -> gnts in consecutive cycles; read ack returns 0x00000005.
5. Reset mid-operation: req0 is granted a read, and rst is pulled low 2 ns after the edge -> req_ack=0 immediately. After release, rr_ptr=0 and the first contended grant goes to req0.
6. SRAM_ARB_LOCK_EN: req0 locks and issues read then write to addr 7 while req1 requests continuously -> req1 is not granted until the cycle after req0's unlocked write is granted.
